// File: rtl/traffic_pkg.sv
// Shared lamp/phase encodings, FSM state type and helpers for the
// three-phase traffic arbiter.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_TURN = 2'd1;
  localparam logic [1:0] PH_SIDE = 2'd2;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  function automatic logic [2:0] ph_oh(input logic [1:0] ph);
    case (ph)
      PH_MAIN: return 3'b001;
      PH_TURN: return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_of(
    input state_t     st,
    input logic [1:0] cur,
    input logic [1:0] ph
  );
    if (st == ST_ALLRED || ph != cur) return LAMP_RED;
    else if (st == ST_GREEN)          return LAMP_GREEN;
    else                              return LAMP_YELLOW;
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_rr.sv
// rr_pick3: combinational round-robin choice of the next phase,
// searching from cur+1 (mod 3); returns cur when nothing else pends.
module rr_pick3
  import traffic_pkg::*;
(
  input  logic [2:0] pending,
  input  logic [1:0] cur,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (cur)
      PH_MAIN: nxt = pending[1] ? PH_TURN :
                     pending[2] ? PH_SIDE : PH_MAIN;
      PH_TURN: nxt = pending[2] ? PH_SIDE :
                     pending[0] ? PH_MAIN : PH_TURN;
      default: nxt = pending[0] ? PH_MAIN :
                     pending[1] ? PH_TURN : PH_SIDE;
    endcase
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Three-phase traffic light arbiter (GREEN/YELLOW/ALLRED).
// Define TRAFFIC_PREEMPT_EN to enable emergency preemption to main.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int T_MIN_GREEN = 7,
  parameter int T_MAX_GREEN = 15,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_main,
  input  logic       req_turn,
  input  logic       req_side,
  input  logic       preempt,
  output logic [2:0] main_lamp,
  output logic [2:0] turn_lamp,
  output logic [2:0] side_lamp,
  output logic [1:0] phase_id
);

  localparam int CW = $clog2(T_MAX_GREEN) + 1;
  localparam logic [CW-1:0] C_MIN = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] C_MAX = CW'(T_MAX_GREEN - 1);
  localparam logic [CW-1:0] C_YEL = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] C_AR  = CW'(T_ALLRED - 1);

  state_t        r_state, w_state_n;
  logic [1:0]    r_cur, r_nxt;
  logic [1:0]    w_cur_n, w_nxt_n, w_rr;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_pend, w_pend_n;
  logic [2:0]    w_req, w_cur_oh, w_set, w_clr;
  logic          w_req_cur, w_other, w_pre;

`ifdef TRAFFIC_PREEMPT_EN
  assign w_pre = preempt;
`else
  // Port kept for pin compatibility; has no effect in this build.
  assign w_pre = preempt & 1'b0;
`endif

  assign w_req     = {req_side, req_turn, req_main};
  assign w_cur_oh  = ph_oh(r_cur);
  assign w_req_cur = |(w_req & w_cur_oh);
  assign w_other   = |(r_pend & ~w_cur_oh);

  rr_pick3 u_rr (
    .pending (r_pend),
    .cur     (r_cur),
    .nxt     (w_rr)
  );

  always_comb begin
    w_state_n = r_state;
    w_cur_n   = r_cur;
    w_nxt_n   = r_nxt;
    unique case (r_state)
      ST_GREEN: begin
        if (w_pre && r_cur != PH_MAIN) begin
          w_state_n = ST_YELLOW;
          w_nxt_n   = PH_MAIN;
        end else if (!w_pre && r_cnt >= C_MIN && w_other &&
                     (!w_req_cur || r_cnt >= C_MAX)) begin
          w_state_n = ST_YELLOW;
          w_nxt_n   = w_rr;
        end
      end
      ST_YELLOW: begin
        if (w_pre) w_nxt_n = PH_MAIN;
        if (r_cnt == C_YEL) w_state_n = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (w_pre) w_nxt_n = PH_MAIN;
        if (r_cnt == C_AR) begin
          w_state_n = ST_GREEN;
          w_cur_n   = w_nxt_n;
        end
      end
      default: w_state_n = ST_GREEN;
    endcase
  end

  // A phase's own request is ignored while it is green; clear beats set.
  always_comb begin
    w_set = w_req & ~((r_state == ST_GREEN) ? w_cur_oh : 3'b000);
    w_clr = 3'b000;
    if (r_state != ST_GREEN && w_state_n == ST_GREEN)
      w_clr = ph_oh(w_cur_n);
    w_pend_n = (r_pend | w_set) & ~w_clr;
    if (w_state_n != r_state)  w_cnt_n = '0;
    else if (r_cnt != C_MAX)   w_cnt_n = r_cnt + 1'b1;
    else                       w_cnt_n = r_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_GREEN;
      r_cur     <= PH_MAIN;
      r_nxt     <= PH_MAIN;
      r_cnt     <= '0;
      r_pend    <= '0;
      main_lamp <= LAMP_GREEN;
      turn_lamp <= LAMP_RED;
      side_lamp <= LAMP_RED;
      phase_id  <= PH_MAIN;
    end else begin
      r_state   <= w_state_n;
      r_cur     <= w_cur_n;
      r_nxt     <= w_nxt_n;
      r_cnt     <= w_cnt_n;
      r_pend    <= w_pend_n;
      main_lamp <= lamp_of(w_state_n, w_cur_n, PH_MAIN);
      turn_lamp <= lamp_of(w_state_n, w_cur_n, PH_TURN);
      side_lamp <= lamp_of(w_state_n, w_cur_n, PH_SIDE);
      phase_id  <= w_cur_n;
    end
  end

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Scoreboard bench for traffic_phase_arbiter: per-cycle expected lamps
// are queued by the driver and checked by a negedge monitor.
module tb_traffic_phase_arbiter;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  typedef struct {
    string       tag;
    logic [10:0] v;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       req_main, req_turn, req_side, preempt;
  logic [2:0] main_lamp, turn_lamp, side_lamp;
  logic [1:0] phase_id;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  traffic_phase_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_main  (req_main),
    .req_turn  (req_turn),
    .req_side  (req_side),
    .preempt   (preempt),
    .main_lamp (main_lamp),
    .turn_lamp (turn_lamp),
    .side_lamp (side_lamp),
    .phase_id  (phase_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void report(string tag, logic [10:0] act,
                                 logic [10:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got m/t/s=%b/%b/%b ph=%0d, want %b/%b/%b ph=%0d",
               tag, act[10:8], act[7:5], act[4:2], act[1:0],
               want[10:8], want[7:5], want[4:2], want[1:0]);
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      report(e.tag, {main_lamp, turn_lamp, side_lamp, phase_id}, e.v);
    end
  end

  task automatic push(input string tag, input logic [2:0] m, t, s,
                      input logic [1:0] ph);
    exp_t e;
    e.tag = tag;
    e.v   = {m, t, s, ph};
    q.push_back(e);
  endtask

  task automatic cyc(input string tag, input logic rm, rt, rs, pe,
                     input logic [2:0] m, t, s, input logic [1:0] ph);
    req_main = rm;
    req_turn = rt;
    req_side = rs;
    preempt  = pe;
    push(tag, m, t, s, ph);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input int n,
                      input logic [2:0] m, t, s, input logic [1:0] ph);
    repeat (n) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, m, t, s, ph);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    req_main = 1'b0;
    req_turn = 1'b0;
    req_side = 1'b0;
    preempt  = 1'b0;
    push("in_reset", G, R, R, 2'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Quiet intersection: main holds green forever.
    do_reset();
    idle("idle_main", 50, G, R, R, 2'd0);

    // Side request pulse on cycle 2.
    do_reset();
    idle("b_main", 2, G, R, R, 2'd0);
    cyc("b_req", 1'b0, 1'b0, 1'b1, 1'b0, G, R, R, 2'd0);
    idle("b_main", 4, G, R, R, 2'd0);
    idle("b_yel", 2, Y, R, R, 2'd0);
    idle("b_ar", 1, R, R, R, 2'd0);
    idle("b_side", 1, R, R, G, 2'd2);
`ifdef TRAFFIC_PREEMPT_EN
    cyc("e_pre", 1'b0, 1'b0, 1'b0, 1'b1, R, R, G, 2'd2);
    idle("e_yel", 2, R, R, Y, 2'd2);
    idle("e_ar", 1, R, R, R, 2'd2);
    idle("e_main", 10, G, R, R, 2'd0);
`else
    cyc("b_pre_ign", 1'b0, 1'b0, 1'b0, 1'b1, R, R, G, 2'd2);
    idle("b_side_hold", 20, R, R, G, 2'd2);
`endif

    // Turn and side together: turn first, then side, then hold side.
    do_reset();
    cyc("c_req", 1'b0, 1'b1, 1'b1, 1'b0, G, R, R, 2'd0);
    idle("c_main", 6, G, R, R, 2'd0);
    idle("c_yel", 2, Y, R, R, 2'd0);
    idle("c_ar", 1, R, R, R, 2'd0);
    idle("c_turn", 7, R, G, R, 2'd1);
    idle("c_tyel", 2, R, Y, R, 2'd1);
    idle("c_tar", 1, R, R, R, 2'd1);
    idle("c_side", 20, R, R, G, 2'd2);

    // Main held high with side pending: green extended to the maximum.
    do_reset();
    cyc("d_req", 1'b1, 1'b0, 1'b1, 1'b0, G, R, R, 2'd0);
    repeat (14) cyc("d_main", 1'b1, 1'b0, 1'b0, 1'b0, G, R, R, 2'd0);
    repeat (2) cyc("d_yel", 1'b1, 1'b0, 1'b0, 1'b0, Y, R, R, 2'd0);
    cyc("d_ar", 1'b1, 1'b0, 1'b0, 1'b0, R, R, R, 2'd0);
    repeat (7) cyc("d_side", 1'b1, 1'b0, 1'b0, 1'b0, R, R, G, 2'd2);
    repeat (2) cyc("d_syel", 1'b1, 1'b0, 1'b0, 1'b0, R, R, Y, 2'd2);
    cyc("d_sar", 1'b1, 1'b0, 1'b0, 1'b0, R, R, R, 2'd2);
    repeat (10) cyc("d_main2", 1'b1, 1'b0, 1'b0, 1'b0, G, R, R, 2'd0);
    req_main = 1'b0;

    // Asynchronous reset in the middle of yellow.
    do_reset();
    cyc("f_req", 1'b0, 1'b0, 1'b1, 1'b0, G, R, R, 2'd0);
    idle("f_main", 6, G, R, R, 2'd0);
    req_turn = 1'b1;
    push("f_yel", Y, R, R, 2'd0);
    #6;
    reset = 1'b1;
    #1;
    report("f_async", {main_lamp, turn_lamp, side_lamp, phase_id},
           {G, R, R, 2'd0});
    req_turn = 1'b0;
    @(posedge clk); #1;
    report("f_in_reset", {main_lamp, turn_lamp, side_lamp, phase_id},
           {G, R, R, 2'd0});
    reset = 1'b0;
    idle("f_no_pend", 20, G, R, R, 2'd0);

    repeat (2) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
